// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the CO224 CPU: accepts one instruction per
// handshake and sequences register-file reads, ALU selects, write strobe and PC.
module cpu_control_fsm #(
    parameter int PC_W = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTRUCTION,
    input  logic            INSTR_VALID,
    output logic            INSTR_READY,
    input  logic            ZERO,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      READREG1,
    output logic [2:0]      READREG2,
    output logic [2:0]      WRITEREG,
    output logic [7:0]      IMMEDIATE,
    output logic [2:0]      ALUOP,
    output logic            IMM_SEL,
    output logic            NEG_SEL,
    output logic            WRITEENABLE,
    output logic            BUSY,
    output logic            ILLEGAL
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       imm_sel;
        logic       neg_sel;
        logic       write;
        logic       jump;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [7:0] op);
        ctrl_t c;
        c = ctrl_t'(9'd0);
        case (op)
            8'h00: begin c.imm_sel = 1'b1; c.write = 1'b1; end
            8'h01: begin c.write = 1'b1; end
            8'h02: begin c.aluop = 3'b001; c.write = 1'b1; end
            8'h03: begin c.aluop = 3'b001; c.neg_sel = 1'b1; c.write = 1'b1; end
            8'h04: begin c.aluop = 3'b010; c.write = 1'b1; end
            8'h05: begin c.aluop = 3'b011; c.write = 1'b1; end
            8'h06: begin c.jump = 1'b1; end
            8'h07: begin c.aluop = 3'b001; c.neg_sel = 1'b1; c.branch = 1'b1; end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    state_t          r_state;
    state_t          w_next_state;
    ctrl_t           w_ctrl;
    logic            w_ready;
    logic            w_accept;
    logic            w_unused;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_offset_ext;
    logic [PC_W-1:0] w_pc_target;

    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_readreg1;
    logic [2:0]      r_readreg2;
    logic [2:0]      r_writereg;
    logic [7:0]      r_immediate;
    logic [7:0]      r_offset;
    logic [2:0]      r_aluop;
    logic            r_imm_sel;
    logic            r_neg_sel;
    logic            r_write;
    logic            r_jump;
    logic            r_branch;
    logic            r_take;
    logic            r_we;
    logic            r_illegal;

    assign w_ctrl   = decode_op(INSTRUCTION[31:24]);
    assign w_ready  = (r_state == S_IDLE) && !RESET;
    assign w_accept = INSTR_VALID && w_ready;
    assign w_unused = &{1'b0, INSTRUCTION[15:11]};

    // Word offset is sign-extended and scaled to bytes; sums wrap silently.
    assign w_offset_ext = {{(PC_W-10){r_offset[7]}}, r_offset, 2'b00};
    assign w_pc_plus4   = r_pc + PC_W'(3'd4);
    assign w_pc_target  = w_pc_plus4 + w_offset_ext;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: only IDLE waits; the other states advance every cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_DECODE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DECODE:    w_next_state = S_EXECUTE;
            S_EXECUTE:   w_next_state = S_WRITEBACK;
            S_WRITEBACK: w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Instruction fields and decoded controls, captured at the accepting edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_readreg1  <= 3'd0;
            r_readreg2  <= 3'd0;
            r_writereg  <= 3'd0;
            r_immediate <= 8'd0;
            r_offset    <= 8'd0;
            r_aluop     <= 3'd0;
            r_imm_sel   <= 1'b0;
            r_neg_sel   <= 1'b0;
            r_write     <= 1'b0;
            r_jump      <= 1'b0;
            r_branch    <= 1'b0;
        end else if (w_accept) begin
            r_readreg1  <= INSTRUCTION[10:8];
            r_readreg2  <= INSTRUCTION[2:0];
            r_writereg  <= INSTRUCTION[18:16];
            r_immediate <= INSTRUCTION[7:0];
            r_offset    <= INSTRUCTION[23:16];
            r_aluop     <= w_ctrl.aluop;
            r_imm_sel   <= w_ctrl.imm_sel;
            r_neg_sel   <= w_ctrl.neg_sel;
            r_write     <= w_ctrl.write;
            r_jump      <= w_ctrl.jump;
            r_branch    <= w_ctrl.branch;
        end
    end

    // Execution side effects: branch resolution, write strobe, PC, sticky illegal flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_take    <= 1'b0;
            r_we      <= 1'b0;
            r_pc      <= {PC_W{1'b0}};
            r_illegal <= 1'b0;
        end else begin
            r_we <= (r_state == S_EXECUTE) && r_write;
            if (r_state == S_EXECUTE) begin
                r_take <= r_jump || (r_branch && ZERO);
            end
            if (r_state == S_WRITEBACK) begin
                r_pc <= r_take ? w_pc_target : w_pc_plus4;
            end
            if (w_accept && w_ctrl.illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign INSTR_READY = w_ready;
    assign BUSY        = (r_state != S_IDLE);
    assign PC          = r_pc;
    assign READREG1    = r_readreg1;
    assign READREG2    = r_readreg2;
    assign WRITEREG    = r_writereg;
    assign IMMEDIATE   = r_immediate;
    assign ALUOP       = r_aluop;
    assign IMM_SEL     = r_imm_sel;
    assign NEG_SEL     = r_neg_sel;
    assign WRITEENABLE = r_we;
    assign ILLEGAL     = r_illegal;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: hand-computed vector table, reset
// corner cases, and randomized instructions against an architectural model.
module tb_cpu_control_fsm;

    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        ZERO;
    logic [31:0] PC;
    logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL, NEG_SEL, WRITEENABLE, BUSY, ILLEGAL;

    cpu_control_fsm #(.PC_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .ZERO(ZERO),
        .PC(PC), .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
        .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
        .WRITEENABLE(WRITEENABLE), .BUSY(BUSY), .ILLEGAL(ILLEGAL)
    );

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic [31:0] pc_before;
        logic [31:0] pc_after;
        logic [2:0]  rr1, rr2, wr, aluop;
        logic [7:0]  imm;
        logic        immsel, negsel, we, ill, chk_ctrl;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_accept = 0;
    vec_t tbl [15];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Architectural model: derives every expected output from the opcode rules
    function automatic vec_t model(input logic [31:0] instr, input logic zero,
                                   input logic [31:0] pc, input logic ill);
        vec_t v;
        int op;
        int off;
        logic taken;
        op  = int'(instr[31:24]);
        off = int'($signed(instr[23:16]));
        v.instr = instr; v.zero = zero; v.pc_before = pc;
        v.rr1 = instr[10:8]; v.rr2 = instr[2:0]; v.wr = instr[18:16]; v.imm = instr[7:0];
        v.aluop  = (op == 2 || op == 3 || op == 7) ? 3'd1 : (op == 4) ? 3'd2 : (op == 5) ? 3'd3 : 3'd0;
        v.immsel = (op == 0);
        v.negsel = (op == 3 || op == 7);
        v.we     = (op <= 5);
        v.chk_ctrl = (op <= 7);
        v.ill    = ill || (op > 7);
        taken    = (op == 6) || (op == 7 && zero);
        v.pc_after = taken ? pc + 32'd4 + 32'(off * 4) : pc + 32'd4;
        return v;
    endfunction

    task automatic chk_decode(input vec_t v, input int k);
        chk($sformatf("READREG1 c%0d", k), 32'(READREG1), 32'(v.rr1));
        chk($sformatf("READREG2 c%0d", k), 32'(READREG2), 32'(v.rr2));
        chk($sformatf("WRITEREG c%0d", k), 32'(WRITEREG), 32'(v.wr));
        chk($sformatf("IMMEDIATE c%0d", k), 32'(IMMEDIATE), 32'(v.imm));
        if (v.chk_ctrl) begin
            chk($sformatf("ALUOP c%0d", k), 32'(ALUOP), 32'(v.aluop));
            chk($sformatf("IMM_SEL c%0d", k), 32'(IMM_SEL), 32'(v.immsel));
            chk($sformatf("NEG_SEL c%0d", k), 32'(NEG_SEL), 32'(v.negsel));
        end
        chk($sformatf("ILLEGAL c%0d", k), 32'(ILLEGAL), 32'(v.ill));
    endtask

    // Entered mid-way through an IDLE cycle; returns mid-way through cycle 4 (IDLE)
    task automatic run_instr(input vec_t v);
        INSTRUCTION = v.instr;
        INSTR_VALID = 1'b1;
        ZERO = ~v.zero;
        #1;
        chk("READY c0", 32'(INSTR_READY), 32'd1);
        chk("PC c0", PC, v.pc_before);
        last_accept = cyc;
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK);
            #1;
            ZERO = (k == 2) ? v.zero : ~v.zero;
            #1;
            chk_decode(v, k);
            chk($sformatf("WE c%0d", k), 32'(WRITEENABLE), 32'((k == 3) && v.we));
            chk($sformatf("BUSY c%0d", k), 32'(BUSY), 32'(k != 4));
            chk($sformatf("READY c%0d", k), 32'(INSTR_READY), 32'(k == 4));
            chk($sformatf("PC c%0d", k), PC, (k == 4) ? v.pc_after : v.pc_before);
        end
    endtask

    task automatic idle(input int n, input logic [31:0] pc);
        INSTR_VALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            #1;
            chk("idle BUSY", 32'(BUSY), 32'd0);
            chk("idle READY", 32'(INSTR_READY), 32'd1);
            chk("idle WE", 32'(WRITEENABLE), 32'd0);
            chk("idle PC", PC, pc);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " READY"}, 32'(INSTR_READY), 32'd1);
        chk({tag, " BUSY"}, 32'(BUSY), 32'd0);
        chk({tag, " WE"}, 32'(WRITEENABLE), 32'd0);
        chk({tag, " PC"}, PC, 32'd0);
        chk({tag, " ILLEGAL"}, 32'(ILLEGAL), 32'd0);
        chk({tag, " decode"}, {READREG1, READREG2, WRITEREG, ALUOP, IMMEDIATE, IMM_SEL, NEG_SEL},
            32'd0);
    endtask

    task automatic do_reset();
        next_cycle();
        RESET = 1'b1;
        INSTR_VALID = 1'b0;
        #1;
        chk("READY in reset", 32'(INSTR_READY), 32'd0);
        next_cycle();
        RESET = 1'b0;
        #1;
        chk_reset_state("post-reset");
    endtask

    initial begin
        RESET = 1'b1; INSTR_VALID = 1'b0; INSTRUCTION = 32'd0; ZERO = 1'b0;
        //            instr         z     pc_before     pc_after      rr1   rr2   wr    alu   imm    is    ns    we    ill   ctl
        tbl[0]  = '{32'h0004005A, 1'b0, 32'h00000000, 32'h00000004, 3'd0, 3'd2, 3'd4, 3'd0, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{32'h03020103, 1'b0, 32'h00000004, 32'h00000008, 3'd1, 3'd3, 3'd2, 3'd1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{32'h06030000, 1'b0, 32'h00000008, 32'h00000018, 3'd0, 3'd0, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{32'h06FD0000, 1'b0, 32'h00000018, 32'h00000010, 3'd0, 3'd0, 3'd5, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{32'h07FE0102, 1'b1, 32'h00000010, 32'h0000000C, 3'd1, 3'd2, 3'd6, 3'd1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{32'h05010203, 1'b0, 32'h0000000C, 32'h00000010, 3'd2, 3'd3, 3'd1, 3'd3, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{32'h07FE0102, 1'b0, 32'h00000010, 32'h00000014, 3'd1, 3'd2, 3'd6, 3'd1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{32'h04071F2E, 1'b0, 32'h00000014, 32'h00000018, 3'd7, 3'd6, 3'd7, 3'd2, 8'h2E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{32'h01050300, 1'b1, 32'h00000018, 32'h0000001C, 3'd3, 3'd0, 3'd5, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{32'hFF123456, 1'b1, 32'h0000001C, 32'h00000020, 3'd4, 3'd6, 3'd2, 3'd0, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{32'h02070506, 1'b0, 32'h00000020, 32'h00000024, 3'd5, 3'd6, 3'd7, 3'd1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{32'h000100FF, 1'b0, 32'h00000024, 32'h00000028, 3'd0, 3'd7, 3'd1, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{32'h07020000, 1'b0, 32'h00000028, 32'h0000002C, 3'd0, 3'd0, 3'd2, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{32'h07800000, 1'b1, 32'h00000000, 32'hFFFFFE04, 3'd0, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{32'h067F0000, 1'b0, 32'hFFFFFE04, 32'h00000004, 3'd0, 3'd0, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();

        // Back-to-back table run with INSTR_VALID held high the whole time
        for (int i = 0; i <= 12; i++) begin
            int prev;
            prev = last_accept;
            run_instr(tbl[i]);
            if (i > 0) chk("accept spacing", 32'(last_accept - prev), 32'd4);
        end
        idle(2, 32'h0000002C);

        // RESET during EXECUTE of an add: no write pulse, PC and ILLEGAL cleared
        INSTRUCTION = 32'h02070506;
        INSTR_VALID = 1'b1;
        next_cycle();
        INSTR_VALID = 1'b0;
        next_cycle();
        RESET = 1'b1;
        #1;
        chk("exec-reset READY", 32'(INSTR_READY), 32'd0);
        chk("exec-reset WE pre", 32'(WRITEENABLE), 32'd0);
        next_cycle();
        RESET = 1'b0;
        #1;
        chk_reset_state("exec-reset");
        idle(3, 32'h00000000);

        // RESET and handshake in the same cycle: the instruction is dropped
        next_cycle();
        RESET = 1'b1;
        INSTRUCTION = 32'h0004005A;
        INSTR_VALID = 1'b1;
        #1;
        chk("reset+hs READY", 32'(INSTR_READY), 32'd0);
        next_cycle();
        RESET = 1'b0;
        INSTR_VALID = 1'b0;
        #1;
        chk_reset_state("reset+hs");
        idle(4, 32'h00000000);

        // Sign extension and modulo wrap of the PC
        run_instr(tbl[13]);
        run_instr(tbl[14]);
        idle(1, 32'h00000004);

        // Randomized instructions against the architectural model
        do_reset();
        begin
            logic [31:0] pc;
            logic        ill;
            pc = 32'd0;
            ill = 1'b0;
            for (int n = 0; n < 80; n++) begin
                logic [31:0] instr;
                int r;
                vec_t v;
                r = $urandom_range(0, 9);
                instr = $urandom;
                instr[31:24] = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
                v = model(instr, 1'($urandom_range(0, 1)), pc, ill);
                run_instr(v);
                pc = v.pc_after;
                ill = v.ill;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), pc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
